// File: rtl/noc_alloc_pkg.sv
// Shared types and helpers for the NoC output-port allocator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package noc_alloc_pkg;

    typedef enum logic [0:0] {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_t;

    // Width of a port index for n ports; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Next port index after idx, wrapping back to 0 after port n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible bit at or after rr_ptr, wrapping.
// Latency: zero cycles, no state.
// Backpressure: none; the caller decides whether the pick is used.
//
// Ports:
//   elig    - eligible requesters
//   rr_ptr  - highest-priority index for this pick
//   winner  - one-hot winner (all zero when nothing is eligible)
//   win_idx - binary index of the winner (0 when nothing is eligible)
//   any     - at least one requester is eligible
module rr_arbiter
    import noc_alloc_pkg::*;
#(
    parameter int N     = 5,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    int w_pos;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        any     = 1'b0;
        w_pos   = 0;
        // Walk the ports starting at rr_ptr; the first eligible one wins.
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(rr_ptr) + k) % N;
            if (!any && elig[w_pos]) begin
                any             = 1'b1;
                winner[w_pos]   = 1'b1;
                win_idx         = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/noc_output_allocator.sv
// Per-output switch allocator + credit counter: round-robin packet grant held until tail.
// Latency: request-to-grant zero cycles; credit return usable next cycle.
// Backpressure: no grant while credits_avail is 0; a locked owner that stops requesting stalls the output.
//
// Ports:
//   clk_noc, rst_noc_sync    - clock, synchronous active-high reset
//   req, req_is_tail         - per-input head flit request and its tail marker
//   disable_mask             - per-input forbidden turn (checked at allocation only)
//   credit_in                - downstream freed one slot
//   grant, grant_valid       - one-hot transfer this cycle and its OR
//   credits_avail, locked    - credit count and packet-in-progress flag
//   err_credit_overflow      - sticky overflow flag, built only with NOC_ALLOC_CREDIT_CHECK_EN
module noc_output_allocator
    import noc_alloc_pkg::*;
#(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   req_is_tail,
    input  logic [NUM_INPUTS-1:0]   disable_mask,
    input  logic                    credit_in,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic                    grant_valid,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    locked,
    output logic                    err_credit_overflow
);

    localparam int IDX_W = idx_width(NUM_INPUTS);
    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    alloc_state_t            r_state;
    logic [IDX_W-1:0]        r_owner;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [CREDIT_WIDTH-1:0] r_credits;

    logic [NUM_INPUTS-1:0]   w_elig;
    logic [NUM_INPUTS-1:0]   w_arb_onehot;
    logic [IDX_W-1:0]        w_arb_idx;
    logic                    w_arb_any;
    logic [NUM_INPUTS-1:0]   w_grant;
    logic [IDX_W-1:0]        w_sel_idx;
    logic                    w_has_credit;
    logic                    w_tail_xfer;
    logic                    w_overflow;

    assign w_elig = req & ~disable_mask;

    rr_arbiter #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .elig    (w_elig),
        .rr_ptr  (r_rr_ptr),
        .winner  (w_arb_onehot),
        .win_idx (w_arb_idx),
        .any     (w_arb_any)
    );

    assign w_has_credit = (r_credits != '0);
    assign w_sel_idx    = (r_state == ALLOC_IDLE) ? w_arb_idx : r_owner;

    // Reset forces the grant low in the same cycle so no flit leaks out.
    always_comb begin
        w_grant = '0;
        if (!rst_noc_sync && w_has_credit) begin
            if (r_state == ALLOC_IDLE) begin
                w_grant = w_arb_onehot;
            end else if (req[r_owner]) begin
                // The mask is deliberately not applied here: a packet already
                // admitted must finish even if its turn is disabled mid-way.
                w_grant[r_owner] = 1'b1;
            end
        end
    end

    assign grant       = w_grant;
    assign grant_valid = |w_grant;
    assign w_tail_xfer = grant_valid && req_is_tail[w_sel_idx];
    // Credit returned into an already-full counter with nothing leaving.
    assign w_overflow  = credit_in && !grant_valid && (r_credits == CRED_MAX);

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_state   <= ALLOC_IDLE;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_credits <= CRED_MAX;
        end else begin
            // Priority rotates per packet: only a tail transfer moves rr_ptr.
            if (w_tail_xfer) begin
                r_state  <= ALLOC_IDLE;
                r_rr_ptr <= IDX_W'(wrap_inc(int'(w_sel_idx), NUM_INPUTS));
            end else if (grant_valid && (r_state == ALLOC_IDLE)) begin
                r_state <= ALLOC_LOCKED;
                r_owner <= w_arb_idx;
            end

            // Saturate at full depth; otherwise a grant spends and a credit refills.
            if (!w_overflow) begin
                r_credits <= r_credits - CREDIT_WIDTH'(grant_valid)
                                       + CREDIT_WIDTH'(credit_in);
            end
        end
    end

    assign credits_avail = r_credits;
    assign locked        = (r_state == ALLOC_LOCKED);

`ifdef NOC_ALLOC_CREDIT_CHECK_EN
    logic r_err_credit_overflow;

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_err_credit_overflow <= 1'b0;
        end else if (w_overflow) begin
            r_err_credit_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (!rst_noc_sync) begin
            assert (!w_overflow)
                else $error("noc_output_allocator: credit returned while counter full");
        end
    end

    assign err_credit_overflow = r_err_credit_overflow;
`else
    assign err_credit_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_noc_output_allocator.sv
// Self-checking bench for noc_output_allocator: directed scenarios plus random traffic
// compared every cycle against a packet-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_noc_output_allocator;

    localparam int N = 5;
    localparam int D = 8;
    localparam int CW = $clog2(D + 1);

    logic          clk_noc = 1'b0;
    logic          rst_noc_sync;
    logic [N-1:0]  req;
    logic [N-1:0]  req_is_tail;
    logic [N-1:0]  disable_mask;
    logic          credit_in;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [CW-1:0] credits_avail;
    logic          locked;
    logic          err_credit_overflow;

    noc_output_allocator #(
        .NUM_INPUTS        (N),
        .FLIT_BUFFER_DEPTH (D),
        .CREDIT_WIDTH      (CW)
    ) dut (
        .clk_noc             (clk_noc),
        .rst_noc_sync        (rst_noc_sync),
        .req                 (req),
        .req_is_tail         (req_is_tail),
        .disable_mask        (disable_mask),
        .credit_in           (credit_in),
        .grant               (grant),
        .grant_valid         (grant_valid),
        .credits_avail       (credits_avail),
        .locked              (locked),
        .err_credit_overflow (err_credit_overflow)
    );

    always #5 clk_noc = ~clk_noc;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the port, whose turn is next, how many slots are free.
    bit m_locked = 1'b0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_cred   = D;
    bit m_err    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs against the model on the
    // falling edge, advance the model, then return just after the rising edge.
    task automatic step(input bit rst, input logic [N-1:0] rq, input logic [N-1:0] tl,
                        input logic [N-1:0] mk, input bit ci,
                        input bit use_lit = 1'b0, input logic [N-1:0] lit = '0);
        logic [N-1:0] exp_g;
        int sel;
        int exp_err;
        rst_noc_sync = rst;
        req          = rq;
        req_is_tail  = tl;
        disable_mask = mk;
        credit_in    = ci;
        @(negedge clk_noc);

        sel = -1;
        if (!rst) begin
            if (!m_locked) begin
                if (m_cred > 0) begin
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (m_ptr + k) % N;
                        if (sel < 0 && rq[i] && !mk[i]) sel = i;
                    end
                end
            end else if (rq[m_owner] && m_cred > 0) begin
                sel = m_owner;
            end
        end
        exp_g = '0;
        if (sel >= 0) exp_g[sel] = 1'b1;
`ifdef NOC_ALLOC_CREDIT_CHECK_EN
        exp_err = int'(m_err);
`else
        exp_err = 0;
`endif
        chk("grant", int'(grant), int'(exp_g));
        chk("grant_valid", int'(grant_valid), (sel >= 0) ? 1 : 0);
        chk("credits_avail", int'(credits_avail), m_cred);
        chk("locked", int'(locked), int'(m_locked));
        chk("err_credit_overflow", int'(err_credit_overflow), exp_err);
        if (use_lit) chk("grant_literal", int'(grant), int'(lit));

        if (rst) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_ptr    = 0;
            m_cred   = D;
            m_err    = 1'b0;
        end else begin
            if (sel >= 0) begin
                if (tl[sel]) begin
                    m_locked = 1'b0;
                    m_ptr    = (sel + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = sel;
                end
            end
            if (ci && sel < 0 && m_cred == D) m_err = 1'b1;
            else m_cred = m_cred - ((sel >= 0) ? 1 : 0) + (ci ? 1 : 0);
        end
        @(posedge clk_noc);
        #1;
    endtask

    initial begin
        logic [N-1:0] one_hot;
        logic [N-1:0] rq;
        logic [N-1:0] tl;
        logic [N-1:0] mk;
        bit ci;
        bit rs;

        // Reset
        repeat (2) step(1'b1, 5'b11111, 5'b11111, '0, 1'b0, 1'b1, 5'b00000);
        chk("reset_credits", int'(credits_avail), 8);
        chk("reset_locked", int'(locked), 0);

        // Fairness: single-flit packets from all inputs rotate 0..4,0
        for (int c = 0; c < 6; c++) begin
            one_hot = 5'b00001 << (c % N);
            step(1'b0, 5'b11111, 5'b11111, '0, 1'b0, 1'b1, one_hot);
        end
        chk("fair_credits", int'(credits_avail), 2);

        // Wormhole: reset for a clean pointer, then input 2 holds the port for 3 flits
        step(1'b1, '0, '0, '0, 1'b0);
        step(1'b0, 5'b00100, 5'b00000, '0, 1'b0, 1'b1, 5'b00100);
        chk("worm_locked", int'(locked), 1);
        step(1'b0, 5'b00110, 5'b00000, '0, 1'b0, 1'b1, 5'b00100);
        step(1'b0, 5'b00110, 5'b00100, '0, 1'b0, 1'b1, 5'b00100);
        chk("worm_unlocked", int'(locked), 0);
        step(1'b0, 5'b00010, 5'b00010, '0, 1'b0, 1'b1, 5'b00010);
        chk("worm_credits", int'(credits_avail), 4);

        // Credit stall while locked to input 0
        for (int c = 0; c < 4; c++) step(1'b0, 5'b00001, 5'b00000, '0, 1'b0, 1'b1, 5'b00001);
        chk("stall_credits_zero", int'(credits_avail), 0);
        step(1'b0, 5'b00001, 5'b00000, '0, 1'b1, 1'b1, 5'b00000);
        step(1'b0, 5'b00001, 5'b00000, '0, 1'b0, 1'b1, 5'b00001);
        chk("stall_back_to_zero", int'(credits_avail), 0);
        step(1'b0, 5'b00000, 5'b00000, '0, 1'b1, 1'b1, 5'b00000);
        step(1'b0, 5'b00001, 5'b00000, '0, 1'b1, 1'b1, 5'b00001);
        chk("grant_and_credit_hold", int'(credits_avail), 1);
        step(1'b0, 5'b00001, 5'b00001, '0, 1'b0, 1'b1, 5'b00001);
        for (int c = 0; c < D; c++) step(1'b0, '0, '0, '0, 1'b1);
        chk("refill_credits", int'(credits_avail), 8);

        // Disabled turn
        step(1'b0, 5'b00001, 5'b00001, 5'b00001, 1'b0, 1'b1, 5'b00000);
        step(1'b0, 5'b01001, 5'b01001, 5'b00001, 1'b0, 1'b1, 5'b01000);
        step(1'b0, '0, '0, '0, 1'b1);

        // Reset mid-packet while locked to input 4
        step(1'b0, 5'b10000, 5'b00000, '0, 1'b0, 1'b1, 5'b10000);
        chk("rst_pre_locked", int'(locked), 1);
        step(1'b1, 5'b10000, 5'b00000, '0, 1'b0, 1'b1, 5'b00000);
        chk("rst_mid_locked", int'(locked), 0);
        chk("rst_mid_credits", int'(credits_avail), 8);
        step(1'b0, 5'b10001, 5'b10001, '0, 1'b0, 1'b1, 5'b00001);
        step(1'b0, '0, '0, '0, 1'b1);

        // Overflow: credit at full count with no grant saturates
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 5'b00000);
        chk("ovf_credits", int'(credits_avail), 8);
`ifdef NOC_ALLOC_CREDIT_CHECK_EN
        chk("ovf_err", int'(err_credit_overflow), 1);
        step(1'b0, '0, '0, '0, 1'b0);
        chk("ovf_err_sticky", int'(err_credit_overflow), 1);
`else
        chk("ovf_err", int'(err_credit_overflow), 0);
`endif
        step(1'b1, '0, '0, '0, 1'b0);

        // Random traffic; credits are only returned when the model has room
        for (int c = 0; c < 3000; c++) begin
            rs = ($urandom_range(0, 199) == 0);
            rq = N'($urandom);
            tl = N'($urandom) & N'($urandom);
            mk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            ci = ($urandom_range(0, 2) != 0) && (m_cred < D);
            step(rs, rq, tl, mk, ci);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
